// File: rtl/bcd_conv_scheduler_pkg.sv
// rtl/bcd_conv_scheduler_pkg.sv - shared widths, blank sentinels and FSM encoding
package bcd_conv_scheduler_pkg;

    localparam int BIN_W = 16;
    localparam int BCD_W = 20;

    localparam logic [15:0] BLANK_BIN = 16'hFFFF;
    localparam logic [19:0] BLANK_BCD = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_conv_scheduler_arbiter.sv
// rtl/bcd_conv_scheduler_arbiter.sv - combinational round-robin grant from an eligible mask
module bcd_rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  i_eligible,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [N_CH-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid
);

    function automatic int wrap_add(input int base, input int ofs);
        int s;
        s = base + ofs;
        if (s >= N_CH) s = s - N_CH;
        return s;
    endfunction

    // First eligible channel scanning upward from the pointer, wrapping at N_CH.
    always_comb begin
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!o_gnt_valid && i_eligible[wrap_add(int'(i_rr_ptr), k)]) begin
                o_gnt_valid                         = 1'b1;
                o_gnt[wrap_add(int'(i_rr_ptr), k)]  = 1'b1;
                o_gnt_idx                           = IDX_W'(wrap_add(int'(i_rr_ptr), k));
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// rtl/bcd_conv_scheduler.sv - time-shares one external binary-to-BCD converter among N_CH requesters
module bcd_conv_scheduler
    import bcd_conv_scheduler_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int BIN_W  = bcd_conv_scheduler_pkg::BIN_W,
    parameter int BCD_W  = bcd_conv_scheduler_pkg::BCD_W,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*BIN_W-1:0] bin_in,
    output logic [N_CH-1:0]       ack,
    output logic [N_CH*BCD_W-1:0] bcd_out,
    output logic [N_CH-1:0]       valid,
    output logic [BIN_W-1:0]      conv_bin,
    input  logic [BCD_W-1:0]      conv_bcd,
    output logic                  busy
);

    localparam int          IDX_W       = $clog2(N_CH);
    localparam logic [2:0]  SETTLE_INIT = 3'(SETTLE - 1);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_gnt_idx;
    logic [N_CH-1:0]        r_gnt_oh;
    logic [2:0]             r_settle_cnt;
    logic                   r_blank;
    logic [N_CH-1:0]        r_ack;
    logic [N_CH-1:0]        r_valid;
    logic [N_CH*BCD_W-1:0]  r_bcd;
    logic [BIN_W-1:0]       r_conv_bin;
    logic                   r_busy;

    logic [N_CH-1:0]        w_eligible;
    logic [N_CH-1:0]        w_gnt;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_gnt_valid;
    logic [BIN_W-1:0]       w_sel_bin;

    assign w_eligible = req & ~r_ack;
    assign w_sel_bin  = bin_in[w_gnt_idx*BIN_W +: BIN_W];

    bcd_rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_eligible  (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_gnt       (w_gnt),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_gnt_idx    <= '0;
            r_gnt_oh     <= '0;
            r_settle_cnt <= '0;
            r_blank      <= 1'b0;
            r_ack        <= '0;
            r_valid      <= '0;
            r_bcd        <= {N_CH{BLANK_BCD}};
            r_conv_bin   <= BLANK_BIN;
            r_busy       <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    // The ack cycle is a recovery slot, giving SETTLE+3 cycles per conversion.
                    if (w_gnt_valid && (r_ack == '0)) begin
                        r_gnt_idx  <= w_gnt_idx;
                        r_gnt_oh   <= w_gnt;
                        r_conv_bin <= w_sel_bin;
                        r_busy     <= 1'b1;
                        if (w_sel_bin == BLANK_BIN) begin
                            r_blank <= 1'b1;
                            r_state <= CAPTURE;
                        end else begin
                            r_blank      <= 1'b0;
                            r_settle_cnt <= SETTLE_INIT;
                            r_state      <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    if (r_settle_cnt == 3'd0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 3'd1;
                    end
                end
                CAPTURE: begin
                    r_bcd[r_gnt_idx*BCD_W +: BCD_W] <= r_blank ? BLANK_BCD : conv_bcd;
                    r_valid  <= r_valid | r_gnt_oh;
                    r_ack    <= r_gnt_oh;
                    r_rr_ptr <= (r_gnt_idx == IDX_W'(N_CH - 1)) ? '0 : r_gnt_idx + 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign bcd_out  = r_bcd;
    assign valid    = r_valid;
    assign conv_bin = r_conv_bin;
    assign busy     = r_busy;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb/tb_bcd_conv_scheduler.sv - directed self-checking bench for bcd_conv_scheduler
module tb_bcd_conv_scheduler;

    localparam int N_CH  = 4;
    localparam int BIN_W = 16;
    localparam int BCD_W = 20;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       req;
    logic [N_CH*BIN_W-1:0] bin_in;
    logic [N_CH-1:0]       ack;
    logic [N_CH*BCD_W-1:0] bcd_out;
    logic [N_CH-1:0]       valid;
    logic [BIN_W-1:0]      conv_bin;
    logic [BCD_W-1:0]      conv_bcd;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [19:0] bin2bcd(input logic [15:0] b);
        logic [19:0] d;
        d = '0;
        for (int i = 15; i >= 0; i--) begin
            for (int n = 0; n < 5; n++) begin
                if (d[4*n +: 4] >= 4'd5) d[4*n +: 4] = d[4*n +: 4] + 4'd3;
            end
            d = {d[18:0], b[i]};
        end
        return d;
    endfunction

    assign conv_bcd = bin2bcd(conv_bin);

    bcd_conv_scheduler #(
        .N_CH   (N_CH),
        .BIN_W  (BIN_W),
        .BCD_W  (BCD_W),
        .SETTLE (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .bin_in   (bin_in),
        .ack      (ack),
        .bcd_out  (bcd_out),
        .valid    (valid),
        .conv_bin (conv_bin),
        .conv_bcd (conv_bcd),
        .busy     (busy)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        req    = '0;
        bin_in = '0;
        step(2);
        checks++;
        if (bcd_out !== {N_CH{20'hFFFFF}}) begin
            errors++; $display("FAIL reset_bcd_out got %h want all FFFFF", bcd_out);
        end
        checks++;
        if (valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", valid); end
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        checks++;
        if (conv_bin !== 16'hFFFF) begin errors++; $display("FAIL reset_conv_bin got %h want FFFF", conv_bin); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_single_ch0();
        logic [3:0] exp_ack  [1:4];
        logic       exp_busy [1:4];
        exp_ack  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
        exp_busy = '{1'b1, 1'b1, 1'b0, 1'b0};
        bin_in[0*16 +: 16] = 16'd1234;
        req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            checks++;
            if (ack !== exp_ack[c]) begin
                errors++; $display("FAIL single_ack c=%0d got %b want %b", c, ack, exp_ack[c]);
            end
            checks++;
            if (busy !== exp_busy[c]) begin
                errors++; $display("FAIL single_busy c=%0d got %b want %b", c, busy, exp_busy[c]);
            end
            if (c == 3) req = 4'b0000;
        end
        checks++;
        if (bcd_out[0*20 +: 20] !== 20'h01234) begin
            errors++; $display("FAIL single_lane0 got %h want 01234", bcd_out[0*20 +: 20]);
        end
        checks++;
        if (bcd_out[20 +: 60] !== {3{20'hFFFFF}}) begin
            errors++; $display("FAIL single_other_lanes got %h want FFFFF x3", bcd_out[20 +: 60]);
        end
        checks++;
        if (valid !== 4'b0001) begin errors++; $display("FAIL single_valid got %b want 0001", valid); end
    endtask

    task automatic test_sentinel_ch2();
        logic [3:0] exp_ack  [1:4];
        logic       exp_busy [1:4];
        bin_in[2*16 +: 16] = 16'd65534;
        req = 4'b0100;
        step(3);
        checks++;
        if (ack !== 4'b0100) begin errors++; $display("FAIL fffe_ack got %b want 0100", ack); end
        checks++;
        if (bcd_out[2*20 +: 20] !== 20'h65534) begin
            errors++; $display("FAIL fffe_lane2 got %h want 65534", bcd_out[2*20 +: 20]);
        end
        req = 4'b0000;
        step(2);
        exp_ack  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
        exp_busy = '{1'b1, 1'b0, 1'b0, 1'b0};
        bin_in[2*16 +: 16] = 16'hFFFF;
        req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            checks++;
            if (ack !== exp_ack[c]) begin
                errors++; $display("FAIL blank_ack c=%0d got %b want %b", c, ack, exp_ack[c]);
            end
            checks++;
            if (busy !== exp_busy[c]) begin
                errors++; $display("FAIL blank_busy c=%0d got %b want %b", c, busy, exp_busy[c]);
            end
            if (c == 2) req = 4'b0000;
        end
        checks++;
        if (bcd_out[2*20 +: 20] !== 20'hFFFFF) begin
            errors++; $display("FAIL blank_lane2 got %h want FFFFF", bcd_out[2*20 +: 20]);
        end
        checks++;
        if (bcd_out[0*20 +: 20] !== 20'h01234) begin
            errors++; $display("FAIL blank_lane0_held got %h want 01234", bcd_out[0*20 +: 20]);
        end
        checks++;
        if (valid !== 4'b0101) begin errors++; $display("FAIL blank_valid got %b want 0101", valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ack [1:20];
        pulse_reset();
        for (int c = 1; c <= 20; c++) exp_ack[c] = 4'b0000;
        exp_ack[3]  = 4'b0001;
        exp_ack[7]  = 4'b0010;
        exp_ack[11] = 4'b0100;
        exp_ack[15] = 4'b1000;
        exp_ack[19] = 4'b0001;
        bin_in = {16'd4444, 16'd333, 16'd22, 16'd1};
        req = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            checks++;
            if (ack !== exp_ack[c]) begin
                errors++; $display("FAIL rr_ack c=%0d got %b want %b", c, ack, exp_ack[c]);
            end
            if (c == 19) req = 4'b0000;
        end
        checks++;
        if (bcd_out !== {20'h04444, 20'h00333, 20'h00022, 20'h00001}) begin
            errors++; $display("FAIL rr_lanes got %h want 04444_00333_00022_00001", bcd_out);
        end
        checks++;
        if (valid !== 4'b1111) begin errors++; $display("FAIL rr_valid got %b want 1111", valid); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_ack [1:4];
        exp_ack = '{4'b0000, 4'b0000, 4'b0010, 4'b0000};
        pulse_reset();
        bin_in[1*16 +: 16] = 16'd777;
        req = 4'b0010;
        step(1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || conv_bin !== 16'hFFFF) begin
            errors++; $display("FAIL mid_abort busy=%b conv_bin=%h want 0 FFFF", busy, conv_bin);
        end
        for (int c = 0; c < 3; c++) begin
            step(1);
            checks++;
            if (ack !== 4'b0000) begin errors++; $display("FAIL mid_ack_in_reset got %b want 0000", ack); end
        end
        checks++;
        if (bcd_out[1*20 +: 20] !== 20'hFFFFF || valid !== 4'b0000) begin
            errors++; $display("FAIL mid_lane1 got %h valid %b want FFFFF 0000", bcd_out[1*20 +: 20], valid);
        end
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            checks++;
            if (ack !== exp_ack[c]) begin
                errors++; $display("FAIL mid_reserve_ack c=%0d got %b want %b", c, ack, exp_ack[c]);
            end
            if (c == 3) req = 4'b0000;
        end
        checks++;
        if (bcd_out[1*20 +: 20] !== 20'h00777) begin
            errors++; $display("FAIL mid_lane1_after got %h want 00777", bcd_out[1*20 +: 20]);
        end
    endtask

    task automatic test_alternate();
        logic [3:0] exp_ack [1:24];
        for (int c = 1; c <= 24; c++) exp_ack[c] = 4'b0000;
        exp_ack[3]  = 4'b1000;
        exp_ack[7]  = 4'b0010;
        exp_ack[11] = 4'b1000;
        exp_ack[15] = 4'b0010;
        exp_ack[19] = 4'b1000;
        exp_ack[23] = 4'b1000;
        bin_in[1*16 +: 16] = 16'd10;
        bin_in[3*16 +: 16] = 16'd99;
        req = 4'b1010;
        for (int c = 1; c <= 24; c++) begin
            step(1);
            checks++;
            if (ack !== exp_ack[c]) begin
                errors++; $display("FAIL alt_ack c=%0d got %b want %b", c, ack, exp_ack[c]);
            end
            if (c == 15) req = 4'b1000;
            if (c == 23) req = 4'b0000;
        end
        checks++;
        if (bcd_out[3*20 +: 20] !== 20'h00099 || bcd_out[1*20 +: 20] !== 20'h00010) begin
            errors++; $display("FAIL alt_lanes got %h %h want 00099 00010",
                               bcd_out[3*20 +: 20], bcd_out[1*20 +: 20]);
        end
    endtask

    initial begin
        test_reset();
        test_single_ch0();
        test_sentinel_ch2();
        test_back_to_back();
        test_reset_mid();
        test_alternate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Shares the single combinational 16-bit-to-5-digit BCD converter (Bin2BCD_5D) among N_CH requesters in the sale terminal, e.g. unit price, quantity, subtotal and change.
- Runs a round-robin arbiter and a small FSM that drives the converter input, waits for it to settle, and captures the result into per-channel display registers.
- Each completed request is answered with a one-cycle ack.
- Sits between the terminal datapath and the 7-segment display drivers.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- BIN_W, 16, binary operand width.
- BCD_W, 20, BCD result width (5 digits).
- SETTLE, 1, cycles the converter input is held before capture (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_CH  per-channel conversion request, level.
- bin_in  in  N_CH*BIN_W  per-channel operand; channel k occupies bits [k*BIN_W +: BIN_W].
- ack  out  N_CH  one-cycle pulse: channel result written.
- bcd_out  out  N_CH*BCD_W  per-channel registered BCD result.
- valid  out  N_CH  channel holds a result from at least one conversion since reset.
- conv_bin  out  BIN_W  registered operand driven to the shared converter.
- conv_bcd  in  BCD_W  converter result.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values (asynchronous, active-high):
  - state IDLE, rr_ptr 0, ack 0, valid 0, busy 0.
  - conv_bin 16'hFFFF (converter idles at blank).
  - every bcd_out lane 20'hFFFFF (blank display).
- FSM states: IDLE, CONVERT, CAPTURE.
- IDLE:
  - Eligible set = req & ~ack. A channel acked this cycle is masked, so a held req is not re-granted on the same cycle.
  - If the eligible set is non-empty, grant the first eligible channel at or after rr_ptr (wrapping N_CH-1 -> 0).
  - On that edge, latch gnt_idx and conv_bin <= bin_in[gnt_idx].
  - If the operand equals 16'hFFFF (blank sentinel), go to CAPTURE directly and mark the result blank.
  - Otherwise go to CONVERT with settle_cnt <= SETTLE-1.
- CONVERT: decrement settle_cnt; when it reaches 0, go to CAPTURE.
- CAPTURE (single cycle):
  - bcd_out[gnt_idx] <= blank ? 20'hFFFFF : conv_bcd.
  - valid[gnt_idx] <= 1.
  - ack[gnt_idx] <= 1 for exactly one cycle (registered).
  - rr_ptr <= (gnt_idx+1) mod N_CH.
  - Return to IDLE.
- Latency, with req first high in cycle T while IDLE:
  - Normal operand: ack high in cycle T+SETTLE+2; bcd_out valid the same cycle.
  - Sentinel operand: ack high in cycle T+2.
  - Back-to-back throughput: one conversion per SETTLE+3 cycles.
- Handshake:
  - Requester holds req until it sees ack, then drops req or leaves it high to request again.
  - bin_in is sampled only at grant; later changes affect only the next request.
  - req dropped after grant: the conversion still completes and is acked.
- Lanes not being written hold their value; only the granted lane changes.
- Simultaneous requests: strict round-robin. With all N_CH requesting continuously, each channel is served once per N_CH conversions; no starvation.
- conv_bcd values other than the sentinel pass through unchecked. The converter's own FFFF handling is not relied upon.
- Reset mid-operation (any state): abort immediately, no ack issued, all registers return to reset values.
- Out-of-range gnt_idx cannot occur; the arbiter is masked to N_CH.

Decomposition:
- Shared package:
  - BIN_W, BCD_W.
  - BLANK_BIN = 16'hFFFF, BLANK_BCD = 20'hFFFFF.
  - FSM state encoding: IDLE = 2'd0, CONVERT = 2'd1, CAPTURE = 2'd2.
- One sub-module, bcd_rr_arbiter (parameter N_CH):
  - Inputs: eligible mask, rr_ptr.
  - Output: one-hot grant plus index, purely combinational.
- Bin2BCD_5D stays outside the block and connects through conv_bin/conv_bcd so other blocks can reuse it. The bench instantiates it.

Test Plan:
- Reset -> all bcd_out = 20'hFFFFF, valid = 0, ack = 0, conv_bin = 16'hFFFF, busy = 0.
- Ch0 req with bin 1234, SETTLE = 1, req at cycle T -> ack[0] in T+3 only, bcd_out[0] = 20'h01234, valid[0] = 1, other lanes unchanged.
- Ch2 bin 65534 then ch2 bin 16'hFFFF -> bcd_out[2] = 20'h65534; then 20'hFFFFF with ack at T+2, and no CONVERT cycle observed on busy.
- Ch0..3 all req at once with bins 1, 22, 333, 4444, held high -> acks in order 0, 1, 2, 3, then 0 again; lanes = 00001, 00022, 00333, 04444; spacing SETTLE+3 cycles.
- Ch1 req, reset asserted during CONVERT -> no ack[1], bcd_out[1] = 20'hFFFFF; after release, the held req is re-served with ack at T+3.
- Ch3 req held continuously alongside ch1 -> ch3 and ch1 alternate. Ch3 alone held -> re-granted one cycle after ack, never double-acked in consecutive cycles.
